neuro_spider_core: RTL and testbench

NEURO_SPIDER_CORE -- requirements
Module: neuro_spider

---
 rtl/neuro_spider_core_if.sv | 14 +
 rtl/neuro_spider_core.sv | 188 ++++++++++++++++++
 tb/tb_neuro_spider_core.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuro_spider_core_if.sv
// Host bus of the neuron core: start strobe, register/cache access, ready flag.
interface neuro_spider_core_if;
  logic        StartOperation;
  logic        WE;
  logic [15:0] Address;
  logic [15:0] DataWrite;
  logic [15:0] DataRead;
  logic        ReadyNextOperation;

  modport master (output StartOperation, WE, Address, DataWrite,
                  input  DataRead, ReadyNextOperation);
  modport slave  (input  StartOperation, WE, Address, DataWrite,
                  output DataRead, ReadyNextOperation);
endinterface

// File: rtl/neuro_spider_core.sv
// Single-neuron MAC engine: sum of L0[I0[k]]*W0[k] in binary16 (round toward zero,
// flush-to-zero, saturating), optional ReLU, result stored in the output cache.
module neuro_spider_core (
  input  logic                clk,
  input  logic                rst,
  neuro_spider_core_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MUL, S_ACC, S_ACT, S_WRITE} state_e;

  state_e      state_q;
  logic [15:0] offset_q, dest_q, numops_q, csel_q, act_q;
  logic [7:0]  k_q;
  logic [15:0] cnt_q;
  logic [15:0] l_q, w_q, prod_q, acc_q, res_q;
  logic        ready_q;

  logic [15:0] l0_mem [256];
  logic [15:0] i0_mem [256];
  logic [15:0] w0_mem [256];
  logic [15:0] lo_mem [256];

  logic        idle, host_wr, cache_wr, reg_wr;
  logic [15:0] rd_data;

  // binary16 multiply, truncating; exponent 0 inputs are zeros, exponent 31 inputs are infinities
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0]       p;
    logic signed [7:0] e;
    logic [9:0]        m;
    logic              s;
    logic [15:0]       y;
    s = a[15] ^ b[15];
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = 8'(int'(a[14:10]) + int'(b[14:10]) - 15 + int'(p[21]));
    m = 10'((p[21] ? p : (p << 1)) >> 11);
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) y = {s, 5'h1f, 10'h0};
    else if (a[14:10] == 5'h0 || b[14:10] == 5'h0) y = {s, 15'h0};
    else if (e >= 8'sd31) y = {s, 5'h1f, 10'h0};
    else if (e <= 8'sd0)  y = {s, 15'h0};
    else                  y = {s, e[4:0], m};
    return y;
  endfunction

  // binary16 add: exact sum on a 44-bit aligned datapath (exponent gap <= 29), then truncate
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic              a_z, b_z, swap;
    logic [15:0]       big, sml, y;
    logic [4:0]        d;
    logic [42:0]       mb, ms;
    logic [43:0]       r;
    logic [9:0]        m;
    logic signed [7:0] e;
    int                pos;
    a_z  = (a[14:10] == 5'h0);
    b_z  = (b[14:10] == 5'h0);
    swap = (b[14:0] > a[14:0]);
    big  = swap ? b : a;
    sml  = swap ? a : b;
    d    = big[14:10] - sml[14:10];
    mb   = {1'b1, big[9:0], 32'h0};
    ms   = 43'({1'b1, sml[9:0], 32'h0} >> d);
    r    = (big[15] == sml[15]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    pos  = 0;
    for (int i = 0; i < 44; i++) if (r[i]) pos = i;
    m = (pos >= 10) ? 10'(r >> (pos - 10)) : 10'(r << (10 - pos));
    e = 8'(int'(big[14:10]) + pos - 42);
    if (a[14:10] == 5'h1f)  y = a;
    else if (b[14:10] == 5'h1f) y = b;
    else if (a_z && b_z)    y = {a[15] & b[15], 15'h0};
    else if (a_z)           y = b;
    else if (b_z)           y = a;
    else if (r == 44'h0)    y = 16'h0000;
    else if (e >= 8'sd31)   y = {big[15], 5'h1f, 10'h0};
    else if (e <= 8'sd0)    y = {big[15], 15'h0};
    else                    y = {big[15], e[4:0], m};
    return y;
  endfunction

  assign idle     = (state_q == S_IDLE);
  // a start on the same edge as a write wins; the write is dropped
  assign host_wr  = idle && bus.WE && !bus.StartOperation;
  assign cache_wr = host_wr && !bus.Address[15];
  assign reg_wr   = host_wr && (bus.Address >= 16'h8000) && (bus.Address <= 16'h8004);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      dest_q   <= '0;
      numops_q <= '0;
      csel_q   <= '0;
      act_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      l_q      <= '0;
      w_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.StartOperation) begin
            k_q     <= offset_q[7:0];
            cnt_q   <= numops_q;
            acc_q   <= '0;
            ready_q <= 1'b0;
            state_q <= (numops_q == 16'h0) ? S_ACT : S_FETCH;
          end else if (reg_wr) begin
            case (bus.Address[2:0])
              3'd0:    offset_q <= bus.DataWrite;
              3'd1:    dest_q   <= bus.DataWrite;
              3'd2:    numops_q <= bus.DataWrite;
              3'd3:    csel_q   <= bus.DataWrite;
              default: act_q    <= bus.DataWrite;
            endcase
          end
        end
        S_FETCH: begin
          l_q     <= l0_mem[i0_mem[k_q][7:0]];
          w_q     <= w0_mem[k_q];
          state_q <= S_MUL;
        end
        S_MUL: begin
          prod_q  <= fmul(l_q, w_q);
          state_q <= S_ACC;
        end
        S_ACC: begin
          acc_q   <= fadd(acc_q, prod_q);
          k_q     <= k_q + 8'd1;
          cnt_q   <= cnt_q - 16'd1;
          state_q <= (cnt_q == 16'd1) ? S_ACT : S_FETCH;
        end
        S_ACT: begin
          res_q   <= (act_q[5] && acc_q[15]) ? 16'h0000 : acc_q;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // cache storage survives reset; an aborted computation never reaches S_WRITE
  always_ff @(posedge clk) begin
    if (cache_wr) begin
      case (csel_q)
        16'd0:   l0_mem[bus.Address[7:0]] <= bus.DataWrite;
        16'd1:   i0_mem[bus.Address[7:0]] <= bus.DataWrite;
        16'd3:   w0_mem[bus.Address[7:0]] <= bus.DataWrite;
        16'd4:   lo_mem[bus.Address[7:0]] <= bus.DataWrite;
        default: ;
      endcase
    end
    if (state_q == S_WRITE) lo_mem[dest_q[7:0]] <= res_q;
  end

  always_comb begin
    rd_data = 16'h0000;
    if (!bus.Address[15]) begin
      case (csel_q)
        16'd0:   rd_data = l0_mem[bus.Address[7:0]];
        16'd1:   rd_data = i0_mem[bus.Address[7:0]];
        16'd3:   rd_data = w0_mem[bus.Address[7:0]];
        16'd4:   rd_data = lo_mem[bus.Address[7:0]];
        default: rd_data = 16'h0000;
      endcase
    end else begin
      case (bus.Address)
        16'h8000: rd_data = offset_q;
        16'h8001: rd_data = dest_q;
        16'h8002: rd_data = numops_q;
        16'h8003: rd_data = csel_q;
        16'h8004: rd_data = act_q;
        default:  rd_data = 16'h0000;
      endcase
    end
  end

  assign bus.DataRead           = rd_data;
  assign bus.ReadyNextOperation = ready_q;

endmodule

// File: tb/tb_neuro_spider_core.sv
// Scoreboarded bench for neuro_spider_core: reads push expected data, a negedge
// monitor pops and compares; results come from a real-arithmetic reference model.
module tb_neuro_spider_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuro_spider_core_if bus ();
  neuro_spider_core dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q [$];
  string       nm_q  [$];
  logic        rd_vld = 1'b0;

  // reference state
  logic [15:0] m_l0 [256], m_i0 [256], m_w0 [256], m_lo [256];
  logic [15:0] m_reg [5];
  bit          m_busy = 0;
  logic [15:0] exp_res;
  logic [7:0]  exp_dest;
  int          exp_len, start_cyc;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endfunction

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got read with no expectation, expected one queued");
      end else chk(nm_q.pop_front(), bus.DataRead, exp_q.pop_front());
    end
  end

  // ---------------- binary16 reference (real arithmetic) ----------------
  function automatic real p2(int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(logic [15:0] h);
    return real'(1024 + int'(h[9:0])) * p2(int'(h[14:10]) - 25);
  endfunction

  // truncate a positive magnitude to binary16 with flush and saturation
  function automatic logic [15:0] pack(bit s, real m);
    int ex, mt;
    if (m >= 65536.0) return {s, 5'h1f, 10'h0};
    if (m < p2(-14))  return {s, 15'h0};
    ex = -14;
    while (m >= p2(ex + 1)) ex++;
    mt = $rtoi(m / p2(ex) * 1024.0) - 1024;
    return {s, 5'(ex + 15), 10'(mt)};
  endfunction

  function automatic logic [15:0] m_mul(logic [15:0] a, logic [15:0] b);
    bit s = a[15] ^ b[15];
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0)   return {s, 15'h0};
    return pack(s, mag(a) * mag(b));
  endfunction

  function automatic logic [15:0] m_add(logic [15:0] a, logic [15:0] b);
    real va, vb, r;
    if (a[14:10] == 5'h1f) return a;
    if (b[14:10] == 5'h1f) return b;
    if (a[14:10] == 5'h0 && b[14:10] == 5'h0) return {a[15] & b[15], 15'h0};
    va = (a[14:10] == 5'h0) ? 0.0 : (a[15] ? -mag(a) : mag(a));
    vb = (b[14:10] == 5'h0) ? 0.0 : (b[15] ? -mag(b) : mag(b));
    r  = va + vb;
    if (r == 0.0) return 16'h0000;
    return pack(r < 0.0, (r < 0.0) ? -r : r);
  endfunction

  function automatic logic [15:0] m_neuron();
    logic [15:0] acc = 16'h0000;
    logic [7:0]  k;
    for (int i = 0; i < int'(m_reg[2]); i++) begin
      k   = 8'(int'(m_reg[0][7:0]) + i);
      acc = m_add(acc, m_mul(m_l0[m_i0[k][7:0]], m_w0[k]));
    end
    return (m_reg[4][5] && acc[15]) ? 16'h0000 : acc;
  endfunction

  function automatic void m_write(logic [15:0] a, logic [15:0] d);
    if (!a[15]) begin
      case (m_reg[3])
        16'd0: m_l0[a[7:0]] = d;
        16'd1: m_i0[a[7:0]] = d;
        16'd3: m_w0[a[7:0]] = d;
        16'd4: m_lo[a[7:0]] = d;
        default: ;
      endcase
    end else if (a >= 16'h8000 && a <= 16'h8004) m_reg[a[2:0]] = d;
  endfunction

  function automatic logic [15:0] m_read(logic [15:0] a);
    if (!a[15]) begin
      case (m_reg[3])
        16'd0: return m_l0[a[7:0]];
        16'd1: return m_i0[a[7:0]];
        16'd3: return m_w0[a[7:0]];
        16'd4: return m_lo[a[7:0]];
        default: return 16'h0000;
      endcase
    end
    if (a >= 16'h8000 && a <= 16'h8004) return m_reg[a[2:0]];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [4:0] e = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(9, 21));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  // ---------------- bus tasks ----------------
  task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
    bus.WE = 1'b1; bus.Address = a; bus.DataWrite = d;
    @(posedge clk); #1;
    bus.WE = 1'b0;
    if (!m_busy) m_write(a, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
    bus.Address = a;
    exp_q.push_back(e); nm_q.push_back(nm);
    rd_vld = 1'b1;
    @(posedge clk); #1;
    rd_vld = 1'b0;
  endtask

  task automatic setregs(input logic [15:0] off, dst, nops, act);
    host_wr(16'h8000, off); host_wr(16'h8001, dst);
    host_wr(16'h8002, nops); host_wr(16'h8004, act);
  endtask

  task automatic start_begin(input bit with_wr, input logic [15:0] wa, input logic [15:0] wd);
    chk("ready_idle", 32'(bus.ReadyNextOperation), 32'd1);
    exp_res  = m_neuron();
    exp_len  = 3 * int'(m_reg[2]) + 2;
    exp_dest = m_reg[1][7:0];
    bus.StartOperation = 1'b1; bus.WE = with_wr; bus.Address = wa; bus.DataWrite = wd;
    @(posedge clk); #1;
    bus.StartOperation = 1'b0; bus.WE = 1'b0;
    start_cyc = cyc; m_busy = 1;
  endtask

  task automatic start_finish();
    while (bus.ReadyNextOperation !== 1'b1 && cyc - start_cyc < 4000) begin
      @(posedge clk); #1;
    end
    chk("busy_len", 32'(cyc - start_cyc), 32'(exp_len));
    m_lo[exp_dest] = exp_res;
    m_busy = 0;
  endtask

  task automatic check_lo(input logic [7:0] idx, input logic [15:0] e, input string nm);
    host_wr(16'h8003, 16'd4);
    rd({8'h00, idx}, e, nm);
  endtask

  task automatic one_term(input logic [7:0] off, idx, input logic [15:0] l, w,
                          input logic [7:0] dst, input logic [15:0] e, input string nm);
    host_wr(16'h8003, 16'd1); host_wr({8'h00, off}, {8'h00, idx});
    host_wr(16'h8003, 16'd0); host_wr({8'h00, idx}, l);
    host_wr(16'h8003, 16'd3); host_wr({8'h00, off}, w);
    setregs({8'h00, off}, {8'h00, dst}, 16'd1, 16'h0000);
    start_begin(0, 16'h0, 16'h0); start_finish();
    check_lo(dst, e, nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.StartOperation = 1'b0; bus.WE = 1'b0; bus.Address = '0; bus.DataWrite = '0;
    foreach (m_reg[i]) m_reg[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ready", 32'(bus.ReadyNextOperation), 32'd1);
    for (int i = 0; i < 5; i++) rd(16'h8000 + 16'(i), 16'h0000, "reset_reg");

    // register/cache access and unmapped select
    host_wr(16'h8003, 16'd3);
    host_wr(16'h0005, 16'h1234);
    rd(16'h0005, 16'h1234, "w0_rdback");
    rd(16'h8003, 16'h0003, "csel_rdback");
    rd(16'h8007, 16'h0000, "unmapped_reg");
    host_wr(16'h8003, 16'd2);
    rd(16'h0005, 16'h0000, "csel2_read");

    // two-term dot product: 1*1 + 2*2 = 5
    host_wr(16'h8003, 16'd0); host_wr(16'h0000, 16'h3C00); host_wr(16'h0001, 16'h4000);
    host_wr(16'h8003, 16'd1); host_wr(16'h0000, 16'h0000); host_wr(16'h0001, 16'h0001);
    host_wr(16'h8003, 16'd3); host_wr(16'h0000, 16'h3C00); host_wr(16'h0001, 16'h4000);
    setregs(16'h0000, 16'h0000, 16'd2, 16'h0000);
    start_begin(0, 16'h0, 16'h0); start_finish();
    check_lo(8'd0, 16'h4500, "dot_5p0");

    // negative result, identity then ReLU
    host_wr(16'h8003, 16'd3); host_wr(16'h0001, 16'hC000);
    start_begin(0, 16'h0, 16'h0); start_finish();
    check_lo(8'd0, 16'hC200, "dot_m3p0");
    host_wr(16'h8004, 16'h0060);
    start_begin(0, 16'h0, 16'h0); start_finish();
    check_lo(8'd0, 16'h0000, "relu_clamp");

    // zero-term operation
    host_wr(16'h8003, 16'd4); host_wr(16'h0007, 16'h5555);
    setregs(16'h0000, 16'h0007, 16'd0, 16'h0000);
    start_begin(0, 16'h0, 16'h0); start_finish();
    check_lo(8'd7, 16'h0000, "numops0");

    // arithmetic corners: saturation, flush, truncation
    one_term(8'h10, 8'h20, 16'h7800, 16'h4000, 8'd2, 16'h7C00, "mul_ovf_inf");
    one_term(8'h11, 8'h21, 16'h0400, 16'hB800, 8'd3, 16'h0000, "mul_flush");
    one_term(8'h12, 8'h22, 16'h3E00, 16'h3C01, 8'd4, 16'h3E01, "mul_rtz");

    // random fill of operand caches
    for (int c = 0; c < 3; c++) begin
      host_wr(16'h8003, (c == 2) ? 16'd3 : 16'(c));
      for (int i = 0; i < 256; i++) host_wr(16'(i), (c == 1) ? 16'($urandom) : rnd_fp());
    end

    // randomized neurons checked against the model
    for (int it = 0; it < 24; it++) begin
      setregs(16'($urandom), 16'($urandom), (it == 5) ? 16'd300 : 16'($urandom_range(0, 12)),
              16'($urandom));
      start_begin(0, 16'h0, 16'h0); start_finish();
      check_lo(exp_dest, m_lo[exp_dest], "rand_neuron");
    end

    // writes and restarts while busy are ignored, reads still work
    host_wr(16'h8003, 16'd4);
    setregs(16'h0040, 16'h0033, 16'd10, 16'h0000);
    start_begin(0, 16'h0, 16'h0);
    host_wr(16'h8002, 16'h0005);
    host_wr(16'h0050, 16'hABCD);
    bus.StartOperation = 1'b1; @(posedge clk); #1; bus.StartOperation = 1'b0;
    rd(16'h8002, m_read(16'h8002), "busy_numops");
    rd(16'h0050, m_read(16'h0050), "busy_cache_wr");
    start_finish();
    check_lo(8'h33, m_lo[8'h33], "busy_result");

    // start and write on the same idle edge: start wins
    setregs(16'h0080, 16'h0034, 16'd4, 16'h0020);
    start_begin(1, 16'h8002, 16'h0009); start_finish();
    rd(16'h8002, 16'd4, "start_wr_drop");
    check_lo(8'h34, m_lo[8'h34], "start_wr_result");

    // reset mid-operation aborts without writing the output cache
    host_wr(16'h0009, 16'h1357);
    setregs(16'h0000, 16'h0009, 16'd5, 16'h0000);
    start_begin(0, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_ready", 32'(bus.ReadyNextOperation), 32'd1);
    foreach (m_reg[i]) m_reg[i] = '0;
    m_busy = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) rd(16'h8000 + 16'(i), 16'h0000, "rst_reg");
    check_lo(8'd9, 16'h1357, "rst_no_write");

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
